// File: rtl/accumulator_pkg.sv
// Shared definitions for the 8-bit accumulator processor.
// Both the datapath and the control unit use these constants.
package accumulator_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    ALU_PASS_B = 4'd0,
    ALU_ADD    = 4'd1,
    ALU_SUB    = 4'd2,
    ALU_AND    = 4'd3,
    ALU_OR     = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_NOT    = 4'd6,
    ALU_SHL    = 4'd7,
    ALU_SHR    = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_JUMP = 2'b10,
    PC_BRZ  = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ACC_ALU  = 2'b00,
    ACC_MEM  = 2'b01,
    ACC_IMM  = 2'b10,
    ACC_HOLD = 2'b11
  } acc_sel_e;

  typedef enum logic [1:0] {
    ADDR_PC   = 2'b00,
    ADDR_IR   = 2'b01,
    ADDR_ACC  = 2'b10,
    ADDR_ONES = 2'b11
  } addr_sel_e;

  // Chain is {PC, IR, ACC, ZF}: ADDR_W + 8 + 8 + 1 bits.
  function automatic int scan_len(input int addr_w);
    return addr_w + 17;
  endfunction

endpackage

// File: rtl/accumulator_alu.sv
// Combinational 8-bit ALU of the accumulator datapath; carries are discarded.
module accumulator_alu
  import accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result
);

  // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    result = a;
    case (opcode)
      ALU_PASS_B: result = b;
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_NOT:    result = ~a;
      ALU_SHL:    result = {a[DATA_W-2:0], 1'b0};
      ALU_SHR:    result = {1'b0, a[DATA_W-1:1]};
      default:    result = a;
    endcase
  end

endmodule

// File: rtl/accumulator_datapath.sv
// Accumulator processor datapath: PC, IR, ACC, ZF, unified memory and the
// register scan chain, driven by per-cycle control words.
module accumulator_datapath
  import accumulator_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PC_write_enable,
  input  logic [1:0]        PC_mux_select,
  input  logic              ACC_write_enable,
  input  logic [1:0]        ACC_mux_select,
  input  logic              IR_load_enable,
  input  logic [3:0]        ALU_opcode,
  input  logic              ALU_inputB_mux_select,
  input  logic              Memory_write_enable,
  input  logic [1:0]        Memory_address_mux_select,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              scan_enable,
  input  logic              scan_in,
  output logic [7:0]        instruction,
  output logic              ZF,
  output logic              scan_out,
  output logic [7:0]        acc_out,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CHAIN_N = scan_len(ADDR_W);

  logic [ADDR_W-1:0]  pc;
  logic [7:0]         ir;
  logic [7:0]         acc;
  logic               zf;
  logic [7:0]         mem [DEPTH];

  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  pc_next;
  logic [7:0]         rdata;
  logic [7:0]         imm;
  logic [7:0]         alu_b;
  logic [7:0]         alu_result;
  logic [7:0]         acc_next;
  logic [CHAIN_N-1:0] chain;
  logic [CHAIN_N-1:0] chain_next;
  logic               prog_collides;

  always_comb begin
    addr = pc;
    case (Memory_address_mux_select)
      ADDR_PC:   addr = pc;
      ADDR_IR:   addr = ir[ADDR_W-1:0];
      ADDR_ACC:  addr = acc[ADDR_W-1:0];
      ADDR_ONES: addr = '1;
      default:   addr = pc;
    endcase
  end

  assign rdata  = mem[addr];
  assign imm    = {4'b0, ir[3:0]};
  assign alu_b  = ALU_inputB_mux_select ? imm : rdata;
  assign pc_inc = pc + ADDR_W'(1);

  accumulator_alu u_alu (
    .a      (acc),
    .b      (alu_b),
    .opcode (ALU_opcode),
    .result (alu_result)
  );

  always_comb begin
    pc_next = pc;
    case (PC_mux_select)
      PC_HOLD: pc_next = pc;
      PC_INC:  pc_next = pc_inc;
      PC_JUMP: pc_next = ir[ADDR_W-1:0];
      PC_BRZ:  pc_next = zf ? ir[ADDR_W-1:0] : pc_inc;
      default: pc_next = pc;
    endcase
  end

  always_comb begin
    acc_next = acc;
    case (ACC_mux_select)
      ACC_ALU:  acc_next = alu_result;
      ACC_MEM:  acc_next = rdata;
      ACC_IMM:  acc_next = imm;
      ACC_HOLD: acc_next = acc;
      default:  acc_next = acc;
    endcase
  end

  // Shift toward ZF: scan_in enters at PC's MSB, ZF leaves on scan_out.
  assign chain      = {pc, ir, acc, zf};
  assign chain_next = {scan_in, chain[CHAIN_N-1:1]};

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      ir  <= '0;
      acc <= '0;
      zf  <= 1'b0;
    end else if (scan_enable) begin
      {pc, ir, acc, zf} <= chain_next;
    end else begin
      if (PC_write_enable) pc <= pc_next;
      if (IR_load_enable)  ir <= rdata;
      if (ACC_write_enable) begin
        acc <= acc_next;
        zf  <= (acc_next == 8'd0);
      end
    end
  end

  // Program load wins when both writers target the same word.
  assign prog_collides = prog_we && (prog_addr == addr);

  // NOTE: memory is register-based and cleared on reset, so it cannot map to a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!scan_enable) begin
      if (Memory_write_enable && !prog_collides) mem[addr] <= acc;
      if (prog_we) mem[prog_addr] <= prog_data;
    end
  end

  assign instruction = ir;
  assign ZF          = zf;
  assign scan_out    = chain[0];
  assign acc_out     = acc;
  assign pc_out      = pc;

endmodule

// File: tb/tb_accumulator_datapath.sv
// Scoreboard bench for accumulator_datapath: the driver pushes the state a
// reference model predicts after each edge, and a monitor compares it.
module tb_accumulator_datapath;

  localparam int AW = 4;
  localparam int CN = 21;

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] ir;
    logic [7:0] acc;
    logic       zf;
  } state_t;

  typedef struct {
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       acc_we;
    logic [1:0] acc_sel;
    logic       ir_ld;
    logic [3:0] op;
    logic       b_sel;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic       pwe;
    logic [3:0] paddr;
    logic [7:0] pdata;
    logic       scan_en;
    logic       sin;
  } ctrl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          PC_write_enable, ACC_write_enable, IR_load_enable;
  logic [1:0]    PC_mux_select, ACC_mux_select, Memory_address_mux_select;
  logic [3:0]    ALU_opcode;
  logic          ALU_inputB_mux_select, Memory_write_enable;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          scan_enable, scan_in;
  logic [7:0]    instruction, acc_out;
  logic          zf_o, scan_out;
  logic [AW-1:0] pc_out;

  accumulator_datapath #(.ADDR_W(AW)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .PC_write_enable           (PC_write_enable),
    .PC_mux_select             (PC_mux_select),
    .ACC_write_enable          (ACC_write_enable),
    .ACC_mux_select            (ACC_mux_select),
    .IR_load_enable            (IR_load_enable),
    .ALU_opcode                (ALU_opcode),
    .ALU_inputB_mux_select     (ALU_inputB_mux_select),
    .Memory_write_enable       (Memory_write_enable),
    .Memory_address_mux_select (Memory_address_mux_select),
    .prog_we                   (prog_we),
    .prog_addr                 (prog_addr),
    .prog_data                 (prog_data),
    .scan_enable               (scan_enable),
    .scan_in                   (scan_in),
    .instruction               (instruction),
    .ZF                        (zf_o),
    .scan_out                  (scan_out),
    .acc_out                   (acc_out),
    .pc_out                    (pc_out)
  );

  int checks   = 0;
  int failures = 0;

  state_t     m;
  logic [7:0] mmem [16];
  state_t     exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic ctrl_t nop();
    ctrl_t c;
    c = '{default: '0};
    return c;
  endfunction

  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai = int'(a);
    int bi = int'(b);
    int r;
    case (op)
      4'd0:    r = bi;
      4'd1:    r = (ai + bi) % 256;
      4'd2:    r = (ai - bi + 256) % 256;
      4'd3:    r = int'(a & b);
      4'd4:    r = int'(a | b);
      4'd5:    r = int'(a ^ b);
      4'd6:    r = 255 - ai;
      4'd7:    r = (ai * 2) % 256;
      4'd8:    r = ai / 2;
      default: r = ai;
    endcase
    return 8'(r);
  endfunction

  task automatic model_reset();
    m = '0;
    for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
  endtask

  // Apply one control word at the falling edge and predict the post-edge state.
  task automatic step(input ctrl_t c);
    state_t     old;
    logic [3:0] a;
    logic [7:0] rd, imm, nacc;
    @(negedge clk);
    PC_write_enable           = c.pc_we;
    PC_mux_select             = c.pc_sel;
    ACC_write_enable          = c.acc_we;
    ACC_mux_select            = c.acc_sel;
    IR_load_enable            = c.ir_ld;
    ALU_opcode                = c.op;
    ALU_inputB_mux_select     = c.b_sel;
    Memory_write_enable       = c.mem_we;
    Memory_address_mux_select = c.addr_sel;
    prog_we                   = c.pwe;
    prog_addr                 = c.paddr;
    prog_data                 = c.pdata;
    scan_enable               = c.scan_en;
    scan_in                   = c.sin;

    old = m;
    case (c.addr_sel)
      2'd0:    a = old.pc;
      2'd1:    a = old.ir[3:0];
      2'd2:    a = old.acc[3:0];
      default: a = 4'd15;
    endcase
    rd  = mmem[a];
    imm = old.ir % 16;

    if (c.scan_en) begin
      m = state_t'({c.sin, old} >> 1);
    end else begin
      if (c.pc_we) begin
        case (c.pc_sel)
          2'd0: m.pc = old.pc;
          2'd1: m.pc = 4'((old.pc + 1) % 16);
          2'd2: m.pc = old.ir[3:0];
          default: m.pc = old.zf ? old.ir[3:0] : 4'((old.pc + 1) % 16);
        endcase
      end
      if (c.ir_ld) m.ir = rd;
      if (c.acc_we) begin
        case (c.acc_sel)
          2'd0:    nacc = alu_ref(c.op, old.acc, c.b_sel ? imm : rd);
          2'd1:    nacc = rd;
          2'd2:    nacc = imm;
          default: nacc = old.acc;
        endcase
        m.acc = nacc;
        m.zf  = (nacc == 8'd0);
      end
      if (c.mem_we) mmem[a] = old.acc;
      if (c.pwe)    mmem[c.paddr] = c.pdata;
    end
    exp_q.push_back(m);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pc"},   32'(pc_out),      32'h0);
    check({tag, "_ir"},   32'(instruction), 32'h0);
    check({tag, "_acc"},  32'(acc_out),     32'h0);
    check({tag, "_zf"},   32'(zf_o),        32'h0);
    check({tag, "_sout"}, 32'(scan_out),    32'h0);
  endtask

  // Monitor: every edge that has a prediction queued is compared just after the edge.
  initial begin
    state_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_pc",   32'(pc_out),      32'(e.pc));
        check("mon_ir",   32'(instruction), 32'(e.ir));
        check("mon_acc",  32'(acc_out),     32'(e.acc));
        check("mon_zf",   32'(zf_o),        32'(e.zf));
        check("mon_sout", 32'(scan_out),    32'(e.zf));
      end
    end
  end

  initial begin
    ctrl_t         c;
    state_t        target;
    logic [CN-1:0] tv, seq;
    int            waited;

    rst_n = 1'b0;
    PC_write_enable = 0; PC_mux_select = 0; ACC_write_enable = 0; ACC_mux_select = 0;
    IR_load_enable = 0; ALU_opcode = 0; ALU_inputB_mux_select = 0; Memory_write_enable = 0;
    Memory_address_mux_select = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    scan_enable = 0; scan_in = 0;
    model_reset();
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      c = nop(); c.pwe = 1; c.paddr = 4'(i);
      c.pdata = (i == 0) ? 8'h15 : (i == 1) ? 8'h23 : 8'($urandom);
      step(c);
    end

    c = nop(); c.acc_we = 1; c.acc_sel = 2'd1; step(c);              // ACC <- mem[0]
    after_edge(); check("load_mem0", 32'(acc_out), 32'h15);
    c = nop(); c.ir_ld = 1; c.pc_we = 1; c.pc_sel = 2'd1; step(c);   // fetch
    after_edge(); check("fetch_ir", 32'(instruction), 32'h15);
    check("fetch_pc", 32'(pc_out), 32'h1);
    c = nop(); c.acc_we = 1; c.acc_sel = 2'd1; step(c);              // ACC <- mem[1]
    after_edge(); check("load_mem1", 32'(acc_out), 32'h23);

    c = nop(); c.acc_we = 1; c.acc_sel = 2'd2; step(c);              // ACC <- 5
    c = nop(); c.acc_we = 1; c.op = 4'd2; c.b_sel = 1; step(c);      // 5 - 5
    after_edge(); check("sub_acc", 32'(acc_out), 32'h0);
    check("sub_zf", 32'(zf_o), 32'h1);
    c = nop(); c.ir_ld = 1; step(c);                                 // IR <- 8'h23
    c = nop(); c.acc_we = 1; c.op = 4'd1; c.b_sel = 1; step(c);      // 0 + 3
    after_edge(); check("add_acc", 32'(acc_out), 32'h3);
    check("add_zf", 32'(zf_o), 32'h0);

    c = nop(); c.acc_we = 1; c.op = 4'd2; c.b_sel = 1; step(c);      // 3 - 3
    c = nop(); c.acc_we = 1; c.op = 4'd6; step(c);                   // ~0 = FF
    c = nop(); c.pwe = 1; c.paddr = 4'hF; c.pdata = 8'h71; step(c);
    c = nop(); c.ir_ld = 1; c.addr_sel = 2'd3; step(c);
    c = nop(); c.acc_we = 1; c.op = 4'd1; c.b_sel = 1; step(c);      // FF + 1
    after_edge(); check("ovf_acc", 32'(acc_out), 32'h0);
    check("ovf_zf", 32'(zf_o), 32'h1);

    c = nop(); c.pwe = 1; c.paddr = 4'hF; c.pdata = 8'h27; step(c);
    c = nop(); c.ir_ld = 1; c.addr_sel = 2'd3; step(c);
    c = nop(); c.pc_we = 1; c.pc_sel = 2'd3; step(c);                // taken
    after_edge(); check("brz_taken", 32'(pc_out), 32'h7);
    c = nop(); c.acc_we = 1; c.acc_sel = 2'd2; step(c);              // ACC <- 7, ZF=0
    c = nop(); c.pc_we = 1; c.pc_sel = 2'd3; step(c);                // not taken
    after_edge(); check("brz_fall", 32'(pc_out), 32'h8);

    c = nop(); c.pwe = 1; c.paddr = 4'hF; c.pdata = 8'h2A; step(c);
    c = nop(); c.ir_ld = 1; c.addr_sel = 2'd3; step(c);
    c = nop(); c.mem_we = 1; c.addr_sel = 2'd1; c.acc_we = 1; c.acc_sel = 2'd2; step(c);
    c = nop(); c.acc_we = 1; c.acc_sel = 2'd1; c.addr_sel = 2'd1; step(c);
    after_edge(); check("memwr_old_acc", 32'(acc_out), 32'h7);

    c = nop(); c.pwe = 1; c.paddr = 4'hF; c.pdata = 8'h3F; step(c);
    c = nop(); c.ir_ld = 1; c.addr_sel = 2'd3; step(c);
    c = nop(); c.pc_we = 1; c.pc_sel = 2'd2; step(c);                // jump to 15
    c = nop(); c.pc_we = 1; c.pc_sel = 2'd1; step(c);
    after_edge(); check("pc_wrap", 32'(pc_out), 32'h0);

    target = '{pc: 4'd3, ir: 8'h15, acc: 8'hAA, zf: 1'b1};
    tv = target;
    for (int k = 0; k < CN; k++) begin
      c = nop(); c.scan_en = 1; c.sin = tv[k]; step(c);
    end
    after_edge(); check("scan_load_acc", 32'(acc_out), 32'hAA);
    check("scan_load_zf", 32'(zf_o), 32'h1);
    for (int k = 0; k < CN; k++) begin
      c = nop(); c.scan_en = 1; c.sin = ~tv[k];
      if (k == 5) begin
        c.pwe = 1; c.paddr = 4'hC; c.pdata = 8'hEE; c.mem_we = 1; c.acc_we = 1;
      end
      step(c);
      seq[k] = scan_out;
    end
    check("scan_seq", 32'(seq), 32'({4'd3, 8'h15, 8'hAA, 1'b1}));
    after_edge();
    check("scan_pc",  32'(pc_out),      32'hC);
    check("scan_ir",  32'(instruction), 32'hEA);
    check("scan_acc", 32'(acc_out),     32'h55);
    check("scan_zf",  32'(zf_o),        32'h0);
    c = nop(); c.acc_we = 1; c.acc_sel = 2'd1; step(c);              // mem[12] untouched
    c = nop(); c.ir_ld = 1; c.addr_sel = 2'd1; step(c);              // mem[10] still 7
    after_edge(); check("scan_mem_kept", 32'(instruction), 32'h07);

    for (int n = 0; n < 400; n++) begin
      c.pc_we    = 1'($urandom);  c.pc_sel  = 2'($urandom);
      c.acc_we   = 1'($urandom);  c.acc_sel = 2'($urandom);
      c.ir_ld    = 1'($urandom);  c.op      = 4'($urandom);
      c.b_sel    = 1'($urandom);  c.mem_we  = 1'($urandom);
      c.addr_sel = 2'($urandom);
      c.pwe      = ($urandom_range(0, 3) == 0);
      c.paddr    = 4'($urandom);  c.pdata   = 8'($urandom);
      c.scan_en  = ($urandom_range(0, 7) == 0);
      c.sin      = 1'($urandom);
      step(c);
    end

    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_cleared("midrun_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      c = nop(); c.acc_we = 1; c.acc_sel = 2'd1; c.pc_we = 1; c.pc_sel = 2'd1;
      c.addr_sel = 2'($urandom);
      step(c);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
